// File: rtl/slc3_pkg.sv
// slc3_pkg: ISDU state encoding, opcodes and the datapath mux/ALU encodings.
package slc3_pkg;
  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S06, S07, S25, S27, S23, S16, P1, P2
  } state_t;
  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_JSR = 4'b0100,
                         OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_NOT = 4'b1001, OP_JMP = 4'b1100, OP_PSE = 4'b1101;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASSA = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00, PC_BUS = 2'b01, PC_ADDER = 2'b10;
  localparam logic [1:0] A2_ZERO = 2'b00, A2_OFF6 = 2'b01, A2_OFF9 = 2'b10, A2_OFF11 = 2'b11;
  function automatic state_t dispatch(input logic [3:0] op);
    case (op)
      OP_ADD:  return S01;
      OP_AND:  return S05;
      OP_NOT:  return S09;
      OP_BR:   return S00;
      OP_JMP:  return S12;
      OP_JSR:  return S04;
      OP_LDR:  return S06;
      OP_STR:  return S07;
      OP_PSE:  return P1;
      default: return S18;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: counts cycles spent in a memory access state; done on the last one.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(MEM_WAIT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign done = count == W'(MEM_WAIT - 1);
endmodule

// File: rtl/slc3_control.sv
// slc3_control: Moore ISDU sequencing fetch/decode/execute and the front-panel pause handshake.
module slc3_control
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  state_t state, next;
  logic wait_st, done;
  assign wait_st = state inside {S33, S25, S16};
  // Held at zero outside the access states so every access starts from a fresh count.
  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk(Clk), .rst(Reset), .clear(!wait_st), .enable(wait_st), .done(done)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= HALTED;
    else state <= next;
  always_comb begin
    next = state;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = '0;
    PCMUX = PC_INC;
    ADDR2MUX = A2_ZERO;
    ALUK = ALU_ADD;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    case (state)
      HALTED: next = Run ? S18 : HALTED;
      S18: begin
        {GatePC, LD_MAR, LD_PC} = '1;
        next = S33;
      end
      S33, S25: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = done;
        if (done) next = state == S33 ? S35 : S27;
      end
      S35: begin
        {GateMDR, LD_IR} = '1;
        next = S32;
      end
      S32: begin
        LD_BEN = 1'b1;
        next = dispatch(Opcode);
      end
      S01, S05, S09: begin
        SR1MUX = 1'b1;
        SR2MUX = state != S09 && IR_5;
        ALUK = state == S01 ? ALU_ADD : state == S05 ? ALU_AND : ALU_NOT;
        {GateALU, LD_REG, LD_CC} = '1;
        next = S18;
      end
      S00: next = BEN ? S22 : S18;
      S22: begin
        ADDR2MUX = A2_OFF9;
        PCMUX = PC_ADDER;
        LD_PC = 1'b1;
        next = S18;
      end
      S12: begin
        {SR1MUX, ADDR1MUX, LD_PC} = '1;
        PCMUX = PC_ADDER;
        next = S18;
      end
      S04: begin
        {GatePC, DRMUX, LD_REG} = '1;
        next = S21;
      end
      S21: begin
        SR1MUX = !IR_11;
        ADDR1MUX = !IR_11;
        ADDR2MUX = IR_11 ? A2_OFF11 : A2_ZERO;
        PCMUX = PC_ADDER;
        LD_PC = 1'b1;
        next = S18;
      end
      S06, S07: begin
        {SR1MUX, ADDR1MUX, GateMARMUX, LD_MAR} = '1;
        ADDR2MUX = A2_OFF6;
        next = state == S06 ? S25 : S23;
      end
      S27: begin
        {GateMDR, LD_REG, LD_CC} = '1;
        next = S18;
      end
      S23: begin
        ALUK = ALU_PASSA;
        {GateALU, LD_MDR} = '1;
        next = S16;
      end
      S16: begin
        Mem_WE = 1'b0;
        if (done) next = S18;
      end
      P1: begin
        LD_LED = 1'b1;
        if (Continue) next = P2;
      end
      P2: begin
        LD_LED = 1'b1;
        if (!Continue) next = S18;
      end
      default: next = HALTED;
    endcase
  end
endmodule

// File: doc/slc3_control.md
# slc3_control

Instruction sequencing and decode unit (ISDU) for the SLC-3 core, directly upstream of the datapath. A Moore state machine walks fetch → decode → execute, driving every datapath load, gate and mux select plus the SRAM strobes. It includes a parameterised memory-wait counter and the Run/Continue/PAUSE front panel handshake.

## Interface
- MEM_WAIT, 2: cycles each memory access state is held (≥1)
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- Run  in  1  start execution from Halted (level)
- Continue  in  1  resume from PAUSE (level)
- Opcode  in  4  IR[15:12]
- IR_5  in  1  immediate select bit
- IR_11  in  1  JSR/JSRR select bit
- BEN  in  1  registered branch enable from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers (one-hot or all zero)
- PCMUX  out  2  00 PC+1, 01 bus, 10 adder
- DRMUX  out  1  0 IR[11:9], 1 R7
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
- SR2MUX  out  1  0 register, 1 sext(IR[4:0])
- ADDR1MUX  out  1  0 PC, 1 SR1
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
- MIO_EN  out  1  1 = MDR loads from memory, 0 = from bus
- Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes

## Operation
- Outputs depend on state only; default all 0, except Mem_OE = Mem_WE = 1.
- Halted: Run=1 → S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC → S33.
- S33: Mem_OE=0, MIO_EN=1; stays MEM_WAIT cycles; LD_MDR only on the last cycle → S35.
- S35: GateMDR, LD_IR → S32.
- S32: LD_BEN.
  - Dispatch on Opcode: ADD 0001→S01, AND 0101→S05, NOT 1001→S09, BR 0000→S00, JMP 1100→S12, JSR 0100→S04, LDR 0110→S06, STR 0111→S07, PAUSE 1101→P1.
  - Any other opcode → S18 (NOP).
- S01 / S05: SR1MUX=1, SR2MUX=IR_5, ALUK=00 (S01) or 01 (S05), GateALU, DRMUX=0, LD_REG, LD_CC → S18.
- S09: SR1MUX=1, ALUK=10, GateALU, DRMUX=0, LD_REG, LD_CC → S18.
- S00: BEN=1 → S22, else S18.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → S18.
- S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC → S18.
- S04: GatePC, DRMUX=1, LD_REG → S21.
- S21:
  - IR_11=1: ADDR1MUX=0, ADDR2MUX=11.
  - IR_11=0: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00.
  - Both cases: PCMUX=10, LD_PC → S18.
- S06 / S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR → S25 / S23.
- S25: same as S33 (MEM_WAIT cycles) → S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC → S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR → S16.
- S16: Mem_WE=0 for MEM_WAIT cycles → S18.
- P1: LD_LED; Continue=1 → P2.
- P2: LD_LED; Continue=0 → S18.

## Timing
- Reset (async, any state, mid-access included): state ← Halted, wait counter ← 0. Outputs take defaults immediately; Mem_WE deasserts combinationally.
- Fetch latency: S18 + MEM_WAIT + S35 + S32 = MEM_WAIT+3 cycles.
- Execute latency:
  - ADD/AND/NOT/JMP: +1.
  - BR: +1 not taken, +2 taken.
  - JSR: +2.
  - LDR: +2+MEM_WAIT.
  - STR: +2+MEM_WAIT.
- Wait counter:
  - Width $clog2(MEM_WAIT+1).
  - Cleared on entry to S33/S25/S16; increments each cycle in those states.
  - Exits when the count equals MEM_WAIT-1.
  - MEM_WAIT=1 gives a single-cycle state with LD_MDR in that cycle.
- Run is sampled only in Halted. Run dropping mid-program has no effect; the machine never returns to Halted except by Reset.
- Continue already high on P1 entry: P1 lasts exactly one cycle.
- Never more than one Gate* high in any state.

## Structure
- slc3_pkg holds:
  - the state_t enum;
  - opcode localparams;
  - ALUK, PCMUX and ADDR2MUX encodings.
  - The datapath imports the same encodings.
- The wait counter is one natural sub-module, mem_wait_counter: clear, enable, done, parameter MEM_WAIT.

## Test plan
- Reset mid-S16 with MEM_WAIT=2 → same-cycle Mem_WE=1, state Halted. Run=1 → S18 with GatePC, LD_MAR, LD_PC.
- Run pulse, Opcode=0001, IR_5=1 → fetch takes 5 cycles. Next cycle SR2MUX=1, ALUK=00, GateALU, LD_REG, LD_CC, then S18.
- Opcode=0000:
  - BEN=0 → S00 then S18, LD_PC never asserted in S00.
  - BEN=1 → S22 with PCMUX=10, ADDR2MUX=10.
- Opcode=0110, MEM_WAIT=3 → Mem_OE=0 for exactly 3 cycles, LD_MDR on the third only, then S27 with GateMDR and LD_REG.
- Opcode=0111 → S23: ALUK=11, MIO_EN=0, LD_MDR. Then S16: Mem_WE=0 for MEM_WAIT cycles.
- Opcode=1101, Continue held 0 for 10 cycles → stays P1 with LD_LED=1. Continue 1 → P2. Continue 0 → S18.
- Opcode=1111 → S32 then S18 with no LD_REG/LD_PC/LD_CC asserted.
